// File: rtl/alu_nibble_sequencer.sv
// Runs W-bit ADD/SUB/INC/DEC/AND/OR/XOR/NOT through an external 4-bit ALU, one nibble per cycle, LSB first.
// Latency NIBBLES+1 cycles from accepted start to done; start is ignored while busy.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero,
  output logic [3:0]   alu_x,
  output logic [3:0]   alu_y,
  output logic [3:0]   alu_select,
  input  logic [3:0]   alu_out,
  input  logic         alu_c_out
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic [IW-1:0] r_idx;
  logic          r_cin;
  logic [W-1:0]  r_result;
  logic          r_carry;
  logic          r_zero;
  logic          w_last;
  logic [W-1:0]  w_result_next;
  logic [1:0]    w_mode;
  logic          w_busy;
  logic          w_done;
  logic [3:0]    w_alu_x;
  logic [3:0]    w_alu_y;
  logic [3:0]    w_alu_select;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ALU arithmetic mode per op: ADD 01, SUB 10, INC 00, DEC 11; carry-in rides in select[0].
  always_comb begin
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_alu_x      = 4'h0;
    w_alu_y      = 4'h0;
    w_alu_select = 4'h0;
    w_mode       = 2'b00;
    case (r_op[1:0])
      2'b00:   w_mode = 2'b01;
      2'b01:   w_mode = 2'b10;
      2'b10:   w_mode = 2'b00;
      default: w_mode = 2'b11;
    endcase
    case (r_state)
      S_RUN: begin
        w_busy       = 1'b1;
        w_alu_x      = r_a[4*r_idx +: 4];
        w_alu_y      = r_b[4*r_idx +: 4];
        w_alu_select = r_op[2] ? {2'b10, r_op[1:0]} : {1'b0, w_mode, r_cin};
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_result_next = r_result;
    w_result_next[4*r_idx +: 4] = alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_idx    <= '0;
            r_cin    <= (op == OP_SUB) || (op == OP_INC);
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          if (!r_op[2]) r_cin <= alu_c_out;
          if (w_last) begin
            r_carry <= r_op[2] ? 1'b0 : alu_c_out;
            r_zero  <= (w_result_next == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = w_busy;
  assign done       = w_done;
  assign result     = r_result;
  assign carry_out  = r_carry;
  assign zero       = r_zero;
  assign alu_x      = w_alu_x;
  assign alu_y      = w_alu_y;
  assign alu_select = w_alu_select;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (NIBBLES=2) with a behavioural model of the external 4-bit ALU.
module tb_alu_nibble_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [3:0] alu_select;
  logic [3:0] alu_out;
  logic       alu_c_out;
  logic [4:0] m_sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
    .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
    .alu_out(alu_out), .alu_c_out(alu_c_out)
  );

  // External ALU model; logic ops drive c_out high so a leaked carry would be visible.
  always_comb begin
    m_sum = 5'h00;
    casez (alu_select)
      4'b000?: m_sum = {1'b0, alu_x} + {4'h0, alu_select[0]};
      4'b001?: m_sum = {1'b0, alu_x} + {1'b0, alu_y} + {4'h0, alu_select[0]};
      4'b010?: m_sum = {1'b0, alu_x} + {1'b0, ~alu_y} + {4'h0, alu_select[0]};
      4'b011?: m_sum = {1'b0, alu_x} + 5'h0F + {4'h0, alu_select[0]};
      4'b1000: m_sum = {1'b1, alu_x & alu_y};
      4'b1001: m_sum = {1'b1, alu_x | alu_y};
      4'b1010: m_sum = {1'b1, alu_x ^ alu_y};
      4'b1011: m_sum = {1'b1, ~alu_x};
      default: m_sum = 5'h00;
    endcase
  end
  assign alu_out   = m_sum[3:0];
  assign alu_c_out = m_sum[4];

  // Drives one operation from IDLE and records what it observed; ends one cycle after done, back in IDLE.
  task automatic do_op(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       output logic [7:0] res, output logic c, output logic z,
                       output logic [3:0] sel0, output logic [3:0] sel1,
                       output logic [3:0] x0, output logic [3:0] y0, output int done_at);
    res = 8'h00; c = 1'b0; z = 1'b0; sel1 = 4'h0; done_at = 0;
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0;
    sel0 = alu_select; x0 = alu_x; y0 = alu_y;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) sel1 = alu_select;
      if (done && done_at == 0) begin
        done_at = i; res = result; c = carry_out; z = zero;
      end
      if (done_at != 0 && i > done_at) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({result, carry_out, zero} !== 10'h000) begin bad++; $display("FAIL reset_outs got=%h/%b/%b want=0", result, carry_out, zero); end
    total++; if ({alu_x, alu_y, alu_select} !== 12'h000) begin bad++; $display("FAIL reset_alu got=%h want=000", {alu_x, alu_y, alu_select}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r; logic c, z; logic [3:0] s0, s1, x0, y0; int d;
    int seen_done;
    start = 1'b1; op = 3'b000; a = 8'h3C; b = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_running got=%b want=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, done, result, carry_out, zero} !== 12'h000) begin bad++; $display("FAIL abort_outs got=%h want=000", {busy, done, result, carry_out, zero}); end
    total++; if ({alu_x, alu_y, alu_select} !== 12'h000) begin bad++; $display("FAIL abort_alu got=%h want=000", {alu_x, alu_y, alu_select}); end
    reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen_done); end
    do_op(3'b000, 8'h3C, 8'h05, r, c, z, s0, s1, x0, y0, d);
    total++; if (d !== 2) begin bad++; $display("FAIL fresh_latency got=%0d want=2", d); end
    total++; if (r !== 8'h41) begin bad++; $display("FAIL fresh_result got=%h want=41", r); end
    total++; if ({c, z} !== 2'b00) begin bad++; $display("FAIL fresh_flags got=%b want=00", {c, z}); end
    total++; if ({x0, y0} !== 8'hC5) begin bad++; $display("FAIL fresh_nibble0 got=%h want=c5", {x0, y0}); end
  endtask

  task automatic test_arith();
    logic [7:0] r; logic c, z; logic [3:0] s0, s1, x0, y0; int d;
    do_op(3'b000, 8'hFF, 8'h01, r, c, z, s0, s1, x0, y0, d);
    total++; if ({s0, s1} !== 8'b0010_0011) begin bad++; $display("FAIL add_sel got=%b want=00100011", {s0, s1}); end
    total++; if ({r, c, z} !== {8'h00, 2'b11}) begin bad++; $display("FAIL add_chain got=%h/%b/%b want=00/1/1", r, c, z); end
    do_op(3'b001, 8'h10, 8'h01, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, z} !== {8'h0F, 2'b10}) begin bad++; $display("FAIL sub_borrow_chain got=%h/%b/%b want=0f/1/0", r, c, z); end
    do_op(3'b001, 8'h00, 8'h01, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, z} !== {8'hFF, 2'b00}) begin bad++; $display("FAIL sub_underflow got=%h/%b/%b want=ff/0/0", r, c, z); end
    do_op(3'b011, 8'h00, 8'h55, r, c, z, s0, s1, x0, y0, d);
    total++; if ({s0, s1} !== 8'b0110_0110) begin bad++; $display("FAIL dec_sel got=%b want=01100110", {s0, s1}); end
    total++; if ({r, c, z} !== {8'hFF, 2'b00}) begin bad++; $display("FAIL dec_wrap got=%h/%b/%b want=ff/0/0", r, c, z); end
    do_op(3'b010, 8'hFF, 8'h55, r, c, z, s0, s1, x0, y0, d);
    total++; if ({s0, s1} !== 8'b0001_0001) begin bad++; $display("FAIL inc_sel got=%b want=00010001", {s0, s1}); end
    total++; if ({r, c, z} !== {8'h00, 2'b11}) begin bad++; $display("FAIL inc_wrap got=%h/%b/%b want=00/1/1", r, c, z); end
  endtask

  task automatic test_logic();
    logic [7:0] r; logic c, z; logic [3:0] s0, s1, x0, y0; int d;
    do_op(3'b100, 8'hA5, 8'h3C, r, c, z, s0, s1, x0, y0, d);
    total++; if ({s0, s1} !== 8'b1000_1000) begin bad++; $display("FAIL and_sel got=%b want=10001000", {s0, s1}); end
    total++; if ({r, c, z} !== {8'h24, 2'b00}) begin bad++; $display("FAIL and_res got=%h/%b/%b want=24/0/0", r, c, z); end
    do_op(3'b101, 8'hA5, 8'h3C, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, s0} !== {8'hBD, 1'b0, 4'b1001}) begin bad++; $display("FAIL or_res got=%h/%b/%b want=bd/0/1001", r, c, s0); end
    do_op(3'b110, 8'hA5, 8'h3C, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, z} !== {8'h99, 2'b00}) begin bad++; $display("FAIL xor_res got=%h/%b/%b want=99/0/0", r, c, z); end
    do_op(3'b111, 8'h5A, 8'h00, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, z} !== {8'hA5, 2'b00}) begin bad++; $display("FAIL not_res got=%h/%b/%b want=a5/0/0", r, c, z); end
    do_op(3'b110, 8'h3C, 8'h3C, r, c, z, s0, s1, x0, y0, d);
    total++; if ({r, c, z} !== {8'h00, 2'b01}) begin bad++; $display("FAIL xor_zero got=%h/%b/%b want=00/0/1", r, c, z); end
  endtask

  task automatic test_start_in_run();
    logic [7:0] r; logic c, z; logic [3:0] s0, s1, x0, y0; int d;
    start = 1'b1; op = 3'b110; a = 8'hFF; b = 8'h0F;
    @(posedge clk); #1;
    op = 3'b100; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++; if ({done, result} !== {1'b1, 8'hF0}) begin bad++; $display("FAIL run_start_ignored got=%b/%h want=1/f0", done, result); end
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, result} !== {1'b0, 8'hF0}) begin bad++; $display("FAIL result_held got=%b/%h want=0/f0", busy, result); end
    total++; if ({alu_x, alu_y, alu_select} !== 12'h000) begin bad++; $display("FAIL idle_alu got=%h want=000", {alu_x, alu_y, alu_select}); end
    do_op(3'b000, 8'h01, 8'h01, r, c, z, s0, s1, x0, y0, d);
    total++; if (r !== 8'h02) begin bad++; $display("FAIL after_ignore got=%h want=02", r); end
  endtask

  task automatic test_back_to_back();
    int n_done, n_idle;
    n_done = 0; n_idle = 0;
    start = 1'b1; op = 3'b000; a = 8'h11; b = 8'h22;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (!busy) n_idle++;
    end
    start = 1'b0;
    total++; if (n_done !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", n_done); end
    total++; if (n_idle !== 3) begin bad++; $display("FAIL b2b_idle_count got=%0d want=3", n_idle); end
    total++; if (result !== 8'h33) begin bad++; $display("FAIL b2b_result got=%h want=33", result); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_arith();
    test_logic();
    test_start_in_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
